// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming-protected shift register stage and its feeders.
//   feeder_state_t : feeder FSM encoding (IDLE, SHIFT, DONE)
//   MODE_*         : mode encodings understood by the downstream register
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } feeder_state_t;

  localparam logic [1:0] MODE_SISO_R = 2'b00;
  localparam logic [1:0] MODE_SISO_L = 2'b01;
  localparam logic [1:0] MODE_PISO   = 2'b10;
  localparam logic [1:0] MODE_PIPO   = 2'b11;

endpackage

// File: rtl/hamming_shift_feeder.sv
// Accepts parallel words over valid/ready and streams them bit-serially into
// the Hamming shift register, then releases enable so the register holds the word.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake; in_data/in_dir captured on acceptance
//   pause           : freezes shifting while high (SHIFT only)
//   serial_in       : bit presented to the register's serial input
//   shift_en, mode  : register enable and mode (SISO right / SISO left)
//   busy            : high in SHIFT or DONE
//   word_done       : one-cycle pulse once the word is resident downstream
module hamming_shift_feeder
  import hamming_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_dir,
  input  logic             pause,
  output logic             serial_in,
  output logic             shift_en,
  output logic [1:0]       mode,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CNT_W = $clog2(width);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] buf_q, buf_d;
  logic             dir_q, dir_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic; the buffer rotates toward the end being sent so the
  // next bit is always at a fixed position.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_data;
          dir_d   = in_dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!pause) begin
          buf_d = dir_q ? {buf_q[width-2:0], buf_q[width-1]}
                        : {buf_q[0], buf_q[width-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(width - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register; shift_en must follow pause in the same
  // cycle so the register and this buffer advance on exactly the same edges.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign word_done = (state_q == DONE);
  assign shift_en  = (state_q == SHIFT) && !pause;
  assign serial_in = (state_q == SHIFT) && (dir_q ? buf_q[width-1] : buf_q[0]);
  assign mode      = dir_q ? MODE_SISO_L : MODE_SISO_R;

endmodule

// File: tb/tb_hamming_shift_feeder.sv
// Self-checking bench for hamming_shift_feeder: a behavioural downstream SISO
// register is driven from the feeder outputs and compared against a scoreboard.
module tb_hamming_shift_feeder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         pause;
  logic         serial_in;
  logic         shift_en;
  logic [1:0]   mode;
  logic         busy;
  logic         word_done;

  hamming_shift_feeder #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .pause     (pause),
    .serial_in (serial_in),
    .shift_en  (shift_en),
    .mode      (mode),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    int           pauses;
  } exp_t;

  exp_t         exp_q[$];
  int           acc_q[$];
  int           done_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           exp_pause = 0;
  int           nb;
  logic         in_flight = 1'b0;
  logic         mode_bad;
  logic [W-1:0] seq;
  logic [W-1:0] reg_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_seq(input logic [W-1:0] d, input logic dir);
    logic [W-1:0] s;
    for (int i = 0; i < int'(W); i++) s[i] = dir ? d[W-1-i] : d[i];
    return s;
  endfunction

  // Downstream register model and scoreboard, evaluated on pre-edge values
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_flight = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back('{data: in_data, dir: in_dir, pauses: exp_pause});
        acc_q.push_back(cyc);
        in_flight = 1'b1;
        nb        = 0;
        seq       = '0;
        mode_bad  = 1'b0;
      end
      if (shift_en && exp_q.size() > 0) begin
        if (nb < int'(W)) seq[nb] = serial_in;
        nb++;
        if (exp_q[0].dir) reg_model = {reg_model[W-2:0], serial_in};
        else              reg_model = {serial_in, reg_model[W-1:1]};
        if (mode !== {1'b0, exp_q[0].dir}) mode_bad = 1'b1;
      end
      if (word_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(word_done), 32'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("reg_word", 32'(reg_model), 32'(e.data));
          check("serial_seq", 32'(seq), 32'(exp_seq(e.data, e.dir)));
          check("en_cycles", 32'(nb), 32'(W));
          check("mode", 32'(mode), 32'({1'b0, e.dir}));
          check("mode_stable", 32'(mode_bad), 32'(0));
          check("done_latency", 32'(cyc - acc_q[acc_q.size()-1]), 32'(int'(W) + 1 + e.pauses));
          done_q.push_back(cyc);
          in_flight = 1'b0;
        end
      end
    end
    cyc++;
  end

  task automatic send(input logic [W-1:0] d, input logic dir, input logic keep);
    logic got_ready;
    got_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ready_wait", 32'(got_ready), 32'(1));
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !busy && exp_q.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    check("idle_wait", 32'(idle), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    check({tag, "_shift_en"}, 32'(shift_en), 32'(0));
    check({tag, "_serial_in"}, 32'(serial_in), 32'(0));
    check({tag, "_mode"}, 32'(mode), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_word_done"}, 32'(word_done), 32'(0));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dir   = 1'b0;
    pause    = 1'b0;
    reg_model = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Right-shift LSB first, then left-shift MSB first
    send(8'hA5, 1'b0, 1'b0);
    check("busy_shift", 32'(busy), 32'(1));
    check("ready_shift", 32'(in_ready), 32'(0));
    wait_idle();
    send(8'hC1, 1'b1, 1'b0);
    check("mode_left_k1", 32'(mode), 32'(2'b01));
    wait_idle();
    check("mode_hold_idle", 32'(mode), 32'(2'b01));

    // Pause for three cycles after the second shift
    exp_pause = 3;
    send(8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pause_en", 32'(shift_en), 32'(0));
      check("pause_bit", 32'(serial_in), 32'(1));
      @(negedge clk);
    end
    pause = 1'b0;
    wait_idle();
    exp_pause = 0;

    // Back-to-back with in_valid held high
    acc_q.delete();
    done_q.delete();
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b0);
    wait_idle();
    check("b2b_accepts", 32'(acc_q.size()), 32'(2));
    check("b2b_dones", 32'(done_q.size()), 32'(2));
    if (acc_q.size() == 2) check("b2b_acc_gap", 32'(acc_q[1] - acc_q[0]), 32'(W + 2));
    if (done_q.size() == 2) check("b2b_done_gap", 32'(done_q[1] - done_q[0]), 32'(W + 2));

    // Reset in the middle of a left shift
    done_q.delete();
    send(8'hC1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (15) @(negedge clk);
    check("midrst_no_done", 32'(done_q.size()), 32'(0));

    // Deliver 0xF0, then idle with noisy, non-valid inputs
    send(8'hF0, 1'b0, 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_data = W'($urandom);
      in_dir  = 1'($urandom);
      pause   = 1'($urandom);
      #1;
      check("idle_ready", 32'(in_ready), 32'(1));
      check("idle_en", 32'(shift_en), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_mode", 32'(mode), 32'(0));
    end
    pause = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_shift_feeder.md
Name: hamming_shift_feeder

Overview:
Upstream feeder for the Hamming-protected shift register stage. It accepts parallel words over a valid/ready handshake and streams them bit-serially into the register's serial_in, driving its enable and mode lines (SISO right or SISO left). Once a word is fully shifted in, it drops enable so the register holds the word and its per-nibble Hamming correction can act. It signals completion with a one-cycle pulse.

Parameters:
width, 8, word length in bits; multiple of 4, minimum 4 (must match the downstream register width)
CNT_W, $clog2(width), bit-counter width (derived; not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  feeder can accept a word
in_data  input  width  word to deliver
in_dir  input  1  0 = SISO right (mode 00), 1 = SISO left (mode 01); sampled with the word
pause  input  1  freeze shifting while high
serial_in  output  1  bit driven to the register's serial_in
shift_en  output  1  drives the register's enable
mode  output  2  drives the register's mode; always 2'b00 or 2'b01
busy  output  1  high in SHIFT or DONE
word_done  output  1  one-cycle pulse when the word is resident in the register

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, bit counter=0, shift buffer=0, dir_q=0.
  - Outputs after reset: in_ready=1, shift_en=0, serial_in=0, mode=2'b00, busy=0, word_done=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, shift_en=0.
  - On an edge with in_valid=1: capture in_data into the shift buffer, capture in_dir into dir_q, clear the counter, go to SHIFT.
  - in_data and in_dir are ignored when in_valid=0.
- mode:
  - mode = {1'b0, dir_q}, registered.
  - Changes only on acceptance; holds its last value in IDLE and DONE.
- SHIFT:
  - in_ready=0. shift_en = ~pause.
  - serial_in = buf[0] when dir_q=0 (LSB first), buf[width-1] when dir_q=1 (MSB first).
  - On each edge with pause=0: rotate the buffer toward the sent end and increment the counter.
  - On the edge where counter==width-1 and pause=0: go to DONE.
  - This gives exactly width enabled cycles. The downstream register then holds in_data exactly, for either direction.
- pause in SHIFT:
  - shift_en=0; counter, buffer, serial_in and mode frozen. Pause may last any number of cycles.
  - pause has no effect in IDLE or DONE.
- DONE:
  - Lasts one cycle: word_done=1, shift_en=0, in_ready=0, then IDLE.
- Latency:
  - Acceptance at edge k. Shift cycles k+1..k+width (no pause). word_done in cycle k+width+1. in_ready high again in cycle k+width+2.
  - Throughput: one word per width+2 cycles.
- Reset mid-operation: the word in flight is discarded; state returns to IDLE with reset values at the next edge. Any partially shifted register content downstream is not repaired by this block.
- No simultaneous accept and complete: in_ready=0 throughout SHIFT and DONE.
- shift_en is never high outside SHIFT. mode never changes while shift_en=1.

Decomposition:
- Shared package hamming_pkg:
  - typedef enum logic [1:0] feeder_state_t {IDLE, SHIFT, DONE}
  - constants MODE_SISO_R=2'b00, MODE_SISO_L=2'b01, MODE_PISO=2'b10, MODE_PIPO=2'b11
  - The downstream register and future stages reuse these.
- No sub-module: FSM, counter and shift buffer stay in a single module.

Test Plan:
1. Reset, then send 0xA5 with in_dir=0 → serial_in sequence over cycles k+1..k+8 = 1,0,1,0,0,1,0,1; mode=00; shift_en high for 8 cycles; word_done in cycle k+9. With the downstream register attached, parallel_out=0xA5 in cycle k+9.
2. Send 0xC1 with in_dir=1 → serial_in = 1,1,0,0,0,0,0,1 (MSB first); mode=01 from cycle k+1; downstream register holds 0xC1.
3. Send 0x3C with pause high for 3 cycles after the 2nd shift → shift_en low 3 cycles, serial_in frozen at bit2=1; total 8 enabled cycles; word_done in cycle k+12; register=0x3C.
4. Hold in_valid high continuously with words 0x11, 0x22 → second acceptance exactly 10 cycles after the first; in_ready=0 between them; two word_done pulses 10 cycles apart.
5. Assert rst in cycle k+4 of a shift → next cycle state IDLE, shift_en=0, in_ready=1, mode=00, no word_done pulse.
6. After delivering 0xF0, flip one data bit in the downstream register while the feeder is idle (shift_en=0) → register corrects back to 0xF0; the feeder keeps all outputs idle.
